// File: rtl/halt_dump_ctl.sv
// Run-control watchdog plus halt-triggered register dump for the CPU debug harness.
// Handshake: a beat transfers on every rising clk edge where dump_valid_o && dump_ready_i; valid never depends on ready.
module halt_dump_ctl #(
   parameter int                IWIDTH  = 16,
   parameter int                RWIDTH  = 16,
   parameter int                NREGS   = 16,
   parameter int                AWIDTH  = 4,
   parameter int                TWIDTH  = 16,
   parameter logic [IWIDTH-1:0] HALT_OP = IWIDTH'(16'hFFFF),
   parameter int                TIMEOUT = 1000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [IWIDTH-1:0] ir_i,
   input  logic              ir_valid_i,
   output logic [AWIDTH-1:0] reg_addr_o,
   input  logic [RWIDTH-1:0] reg_data_i,
   output logic              cpu_halt_o,
   output logic              dump_valid_o,
   input  logic              dump_ready_i,
   output logic [AWIDTH-1:0] dump_idx_o,
   output logic [RWIDTH-1:0] dump_data_o,
   output logic              dump_last_o,
   output logic              done_o,
   output logic              timeout_o,
   output logic [TWIDTH-1:0] cycles_o,
   output logic [2:0]        dbg_state
);

   typedef enum logic [2:0] {
      S_RUN   = 3'd0,
      S_FETCH = 3'd1,
      S_CAPT  = 3'd2,
      S_SEND  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [AWIDTH-1:0] LAST_IDX = AWIDTH'(NREGS - 1);
   localparam logic [TWIDTH-1:0] TO_VAL   = TWIDTH'(TIMEOUT);
   localparam bit                TO_EN    = (TIMEOUT != 0);

   state_t            state, state_nxt;
   logic [AWIDTH-1:0] idx, idx_nxt;
   logic              halt_hit, to_hit;
   logic              capture, to_set;

   assign halt_hit = ir_valid_i && (ir_i == HALT_OP);
   assign to_hit   = TO_EN && (cycles_o == TO_VAL);

   // Halt is tested before the watchdog so a coincident halt still produces a dump.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      capture   = 1'b0;
      to_set    = 1'b0;
      case (state)
         S_RUN: begin
            if (halt_hit) begin
               state_nxt = S_FETCH;
               idx_nxt   = '0;
            end else if (to_hit) begin
               state_nxt = S_DONE;
               to_set    = 1'b1;
            end
         end
         S_FETCH: state_nxt = S_CAPT;
         S_CAPT: begin
            state_nxt = S_SEND;
            capture   = 1'b1;
         end
         S_SEND: begin
            if (dump_ready_i) begin
               if (dump_last_o) begin
                  state_nxt = S_DONE;
               end else begin
                  idx_nxt   = idx + AWIDTH'(1);
                  state_nxt = S_FETCH;
               end
            end
         end
         S_DONE:  state_nxt = S_DONE;
         default: state_nxt = S_RUN;
      endcase
   end

   always_comb begin
      reg_addr_o   = ((state == S_FETCH) || (state == S_CAPT)) ? idx : '0;
      cpu_halt_o   = (state != S_RUN);
      dump_valid_o = (state == S_SEND);
      done_o       = (state == S_DONE);
      dbg_state    = state;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_RUN;
         idx         <= '0;
         cycles_o    <= '0;
         dump_idx_o  <= '0;
         dump_data_o <= '0;
         dump_last_o <= 1'b0;
         timeout_o   <= 1'b0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         // Counter only advances while staying in RUN, so it freezes on the exit edge.
         if ((state == S_RUN) && (state_nxt == S_RUN) && (cycles_o != '1))
            cycles_o <= cycles_o + TWIDTH'(1);
         if (capture) begin
            dump_data_o <= reg_data_i;
            dump_idx_o  <= idx;
            dump_last_o <= (idx == LAST_IDX);
         end
         if (to_set)
            timeout_o <= 1'b1;
      end
   end

endmodule
